// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_pkg
// Description : Shared func3 encodings, predictor counter states and update.
// Revision    : 1.0
// ============================================================================
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_state_e;

    // Two-bit saturating counter step toward the observed outcome.
    function automatic ctr_state_e sat_update(input ctr_state_e state, input logic taken);
        ctr_state_e nxt;
        nxt = state;
        if (taken) begin
            if (state != ST) nxt = ctr_state_e'(state + 2'd1);
        end else begin
            if (state != SNT) nxt = ctr_state_e'(state - 2'd1);
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_cmp.sv
`default_nettype none
// ============================================================================
// Module      : branch_cmp
// Description : Combinational RV32I conditional-branch comparator.
// Revision    : 1.0
// ============================================================================
module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      func3,
    output logic            cond,
    output logic            legal
);

    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        case (func3)
            F3_BEQ:  cond = (a == b);
            F3_BNE:  cond = (a != b);
            F3_BLT:  cond = ($signed(a) <  $signed(b));
            F3_BGE:  cond = ($signed(a) >= $signed(b));
            F3_BLTU: cond = (a <  b);
            F3_BGEU: cond = (a >= b);
            default: legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : EX-stage branch resolution with 2-bit BHT and statistics.
// Revision    : 1.0
// ============================================================================
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int IDX_LSB     = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  f_pc,
    output logic             f_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic [2:0]       ex_func3,
    input  logic [XLEN-1:0]  ex_a,
    input  logic [XLEN-1:0]  ex_b,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    output logic             taken,
    output logic             mispredict,
    output logic             illegal,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    ctr_state_e       bht_q [BHT_ENTRIES];
    logic             taken_q, mispredict_q, illegal_q;
    logic             taken_d, mispredict_d, illegal_d;
    logic [CNT_W-1:0] br_count_q, mp_count_q;
    logic [CNT_W-1:0] br_count_d, mp_count_d;

    logic [IDX_W-1:0] w_f_idx, w_ex_idx;
    logic [1:0]       w_f_entry;
    ctr_state_e       w_bht_upd;
    logic             w_cond, w_legal, w_res;
    logic             w_unused;

    assign w_f_idx  = f_pc[IDX_LSB +: IDX_W];
    assign w_ex_idx = ex_pc[IDX_LSB +: IDX_W];
    assign w_unused = ^{f_pc, ex_pc};

    // Read the pre-update state: a same-cycle EX write is not bypassed.
    assign w_f_entry    = bht_q[w_f_idx];
    assign f_pred_taken = w_f_entry[1];

    branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .a     (ex_a),
        .b     (ex_b),
        .func3 (ex_func3),
        .cond  (w_cond),
        .legal (w_legal)
    );

    assign w_res     = ex_valid & ex_branch & w_legal;
    assign w_bht_upd = sat_update(bht_q[w_ex_idx], w_cond);

    always_comb begin
        taken_d      = w_res & w_cond;
        mispredict_d = w_res & (w_cond != ex_pred_taken);
        illegal_d    = ex_valid & ex_branch & ~w_legal;
        br_count_d   = br_count_q;
        mp_count_d   = mp_count_q;
        if (w_res && (br_count_q != '1)) br_count_d = br_count_q + CNT_W'(1);
        if (mispredict_d && (mp_count_q != '1)) mp_count_d = mp_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= WNT;
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
            illegal_q    <= 1'b0;
            br_count_q   <= '0;
            mp_count_q   <= '0;
        end else begin
            if (w_res) bht_q[w_ex_idx] <= w_bht_upd;
            taken_q      <= taken_d;
            mispredict_q <= mispredict_d;
            illegal_q    <= illegal_d;
            br_count_q   <= br_count_d;
            mp_count_q   <= mp_count_d;
        end
    end

    assign taken      = taken_q;
    assign mispredict = mispredict_q;
    assign illegal    = illegal_q;
    assign br_count   = br_count_q;
    assign mp_count   = mp_count_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Self-checking bench with a behavioural predictor/compare model.
// Revision    : 1.0
// ============================================================================
module tb_branch_resolve_unit;

    localparam int NENT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] f_pc, ex_a, ex_b, ex_pc;
    logic        ex_valid, ex_branch, ex_pred_taken;
    logic [2:0]  ex_func3;

    logic        f_pred_taken, taken, mispredict, illegal;
    logic [15:0] br_count, mp_count;
    logic        f_pred4, taken4, mispredict4, illegal4;
    logic [3:0]  br_count4, mp_count4;

    int checks   = 0;
    int failures = 0;

    int m_bht [NENT];
    int m_br, m_mp;

    always #5 clk = ~clk;

    branch_resolve_unit u_dut (
        .clk           (clk),
        .reset         (reset),
        .f_pc          (f_pc),
        .f_pred_taken  (f_pred_taken),
        .ex_valid      (ex_valid),
        .ex_branch     (ex_branch),
        .ex_func3      (ex_func3),
        .ex_a          (ex_a),
        .ex_b          (ex_b),
        .ex_pc         (ex_pc),
        .ex_pred_taken (ex_pred_taken),
        .taken         (taken),
        .mispredict    (mispredict),
        .illegal       (illegal),
        .br_count      (br_count),
        .mp_count      (mp_count)
    );

    branch_resolve_unit #(.CNT_W(4)) u_dut4 (
        .clk           (clk),
        .reset         (reset),
        .f_pc          (f_pc),
        .f_pred_taken  (f_pred4),
        .ex_valid      (ex_valid),
        .ex_branch     (ex_branch),
        .ex_func3      (ex_func3),
        .ex_a          (ex_a),
        .ex_b          (ex_b),
        .ex_pc         (ex_pc),
        .ex_pred_taken (ex_pred_taken),
        .taken         (taken4),
        .mispredict    (mispredict4),
        .illegal       (illegal4),
        .br_count      (br_count4),
        .mp_count      (mp_count4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One clock of stimulus: check fetch prediction, clock, check registered results.
    task automatic cycle();
        logic legal, cond, res, e_taken, e_mp, e_ill;
        int   eidx, fidx;
        #1;
        fidx = int'(f_pc >> 2) % NENT;
        eidx = int'(ex_pc >> 2) % NENT;
        check("f_pred", 32'(f_pred_taken), 32'(m_bht[fidx] >= 2));
        check("f_pred4", 32'(f_pred4), 32'(m_bht[fidx] >= 2));
        legal = !(ex_func3 == 3'b010 || ex_func3 == 3'b011);
        case (ex_func3)
            3'd0:    cond = (ex_a == ex_b);
            3'd1:    cond = (ex_a != ex_b);
            3'd4:    cond = (int'(ex_a) <  int'(ex_b));
            3'd5:    cond = (int'(ex_a) >= int'(ex_b));
            3'd6:    cond = (ex_a <  ex_b);
            3'd7:    cond = (ex_a >= ex_b);
            default: cond = 1'b0;
        endcase
        res = ex_valid && ex_branch && legal;
        @(posedge clk);
        #1;
        if (reset) begin
            for (int i = 0; i < NENT; i++) m_bht[i] = 1;
            m_br = 0; m_mp = 0;
            e_taken = 0; e_mp = 0; e_ill = 0;
        end else begin
            e_taken = res && cond;
            e_mp    = res && (cond != ex_pred_taken);
            e_ill   = ex_valid && ex_branch && !legal;
            if (res) begin
                m_br++;
                if (cond) m_bht[eidx] = min_i(m_bht[eidx] + 1, 3);
                else      m_bht[eidx] = (m_bht[eidx] > 0) ? m_bht[eidx] - 1 : 0;
            end
            if (e_mp) m_mp++;
        end
        check("taken", 32'(taken), 32'(e_taken));
        check("mispredict", 32'(mispredict), 32'(e_mp));
        check("illegal", 32'(illegal), 32'(e_ill));
        check("br_count", 32'(br_count), 32'(min_i(m_br, 65535)));
        check("mp_count", 32'(mp_count), 32'(min_i(m_mp, 65535)));
        check("br_count4", 32'(br_count4), 32'(min_i(m_br, 15)));
        check("mp_count4", 32'(mp_count4), 32'(min_i(m_mp, 15)));
        check("taken4", 32'(taken4), 32'(e_taken));
    endtask

    task automatic set_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic pred);
        ex_valid = 1'b1; ex_branch = 1'b1; ex_func3 = f3;
        ex_a = a; ex_b = b; ex_pc = pc; ex_pred_taken = pred;
    endtask

    logic [2:0] sweep_f3  [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic       sweep_exp [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        for (int i = 0; i < NENT; i++) m_bht[i] = 1;
        m_br = 0; m_mp = 0;
        reset = 1'b1; f_pc = '0; ex_a = '0; ex_b = '0; ex_pc = '0;
        ex_valid = 1'b0; ex_branch = 1'b0; ex_func3 = '0; ex_pred_taken = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;

        // Reset probes
        f_pc = 32'h00; #1 check("rst_pred_00", 32'(f_pred_taken), 32'd0); cycle();
        f_pc = 32'h3C; #1 check("rst_pred_3c", 32'(f_pred_taken), 32'd0); cycle();
        f_pc = 32'h40; #1 check("rst_pred_40", 32'(f_pred_taken), 32'd0); cycle();
        check("rst_br", 32'(br_count), 32'd0);

        // Func3 sweep
        for (int i = 0; i < 6; i++) begin
            set_br(sweep_f3[i], 32'hFFFF_FFFF, 32'h1, 32'h300, 1'b0);
            cycle();
            check("sweep", 32'(taken), 32'(sweep_exp[i]));
        end
        set_br(3'd0, 32'd5, 32'd5, 32'h300, 1'b0); cycle(); check("eq_beq", 32'(taken), 32'd1);
        set_br(3'd5, 32'd5, 32'd5, 32'h300, 1'b0); cycle(); check("eq_bge", 32'(taken), 32'd1);
        set_br(3'd7, 32'd5, 32'd5, 32'h300, 1'b0); cycle(); check("eq_bgeu", 32'(taken), 32'd1);

        // Predictor training at 0x100 from a fresh table
        reset = 1'b1; ex_valid = 1'b0; cycle(); reset = 1'b0;
        f_pc = 32'h100;
        for (int i = 0; i < 3; i++) begin
            set_br(3'd0, 32'd7, 32'd7, 32'h100, 1'b0);
            cycle();
            check("train_t", 32'(f_pred_taken), 32'd1);
        end
        set_br(3'd1, 32'd7, 32'd7, 32'h100, 1'b1); cycle();
        check("train_nt1", 32'(f_pred_taken), 32'd1);
        cycle();
        check("train_nt2", 32'(f_pred_taken), 32'd0);

        // Mispredict and saturating counts
        reset = 1'b1; ex_valid = 1'b0; cycle(); reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_br(3'd0, 32'd9, 32'd9, 32'h140, 1'b0);
            cycle();
            check("mp_each", 32'(mispredict), 32'd1);
        end
        check("br10", 32'(br_count), 32'd10);
        check("mp10", 32'(mp_count), 32'd10);
        for (int i = 0; i < 10; i++) cycle();
        check("br4_sat", 32'(br_count4), 32'd15);
        check("mp4_sat", 32'(mp_count4), 32'd15);
        check("br20", 32'(br_count), 32'd20);

        // Illegal and bubble
        set_br(3'b010, 32'd1, 32'd1, 32'h140, 1'b1); cycle();
        check("ill", 32'(illegal), 32'd1);
        check("ill_taken", 32'(taken), 32'd0);
        check("ill_cnt", 32'(br_count), 32'd20);
        set_br(3'd0, 32'd1, 32'd1, 32'h140, 1'b1); ex_valid = 1'b0; cycle();
        check("bubble_taken", 32'(taken), 32'd0);
        check("bubble_cnt", 32'(br_count), 32'd20);

        // Reset wins over a resolving branch, then same-index collision
        f_pc = 32'h200;
        set_br(3'd0, 32'd3, 32'd3, 32'h200, 1'b0); cycle();
        set_br(3'd1, 32'd1, 32'd2, 32'h200, 1'b0); reset = 1'b1; cycle(); reset = 1'b0;
        check("rstwin_taken", 32'(taken), 32'd0);
        check("rstwin_br", 32'(br_count), 32'd0);
        check("rstwin_pred", 32'(f_pred_taken), 32'd0);
        set_br(3'd0, 32'd3, 32'd3, 32'h200, 1'b0);
        #1 check("coll_old", 32'(f_pred_taken), 32'd0);
        cycle();
        check("coll_new", 32'(f_pred_taken), 32'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            reset         = ($urandom_range(0, 59) == 0);
            ex_valid      = ($urandom_range(0, 7) != 0);
            ex_branch     = ($urandom_range(0, 5) != 0);
            ex_func3      = 3'($urandom_range(0, 7));
            ex_a          = $urandom;
            ex_b          = ($urandom_range(0, 3) == 0) ? ex_a : $urandom;
            if ($urandom_range(0, 4) == 0) ex_b = ex_a ^ 32'h8000_0000;
            ex_pc         = 32'($urandom_range(0, 31)) << 2;
            f_pc          = ($urandom_range(0, 1) == 1) ? ex_pc : (32'($urandom_range(0, 31)) << 2);
            ex_pred_taken = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
